// File: rtl/debug_pkg.sv
// Shared types and clock-derived timing defaults for the debug single-step controller.
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } step_state_t;

  localparam int CLK_HZ           = 50_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_DELAY_MS  = 500;
  localparam int REPEAT_PERIOD_MS = 100;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/debug_step_ctrl_if.sv
// Board-side signal bundle of the step controller: raw key/switch in, step enable and status out.
interface debug_step_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             key_n_i;
  logic             run_mode_i;
  logic             step_en_o;
  logic             key_level_o;
  logic             run_mode_o;
  logic [CNT_W-1:0] step_count_o;

  modport master (
    output key_n_i,
    output run_mode_i,
    input  step_en_o,
    input  key_level_o,
    input  run_mode_o,
    input  step_count_o
  );

  modport slave (
    input  key_n_i,
    input  run_mode_i,
    output step_en_o,
    output key_level_o,
    output run_mode_o,
    output step_count_o
  );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus debounce counter for an active-low pushbutton.
// key_level changes 2 + DEBOUNCE_CYCLES edges after the first edge sampling a new raw level.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [DW-1:0] cnt;

  // The counter must run through DEBOUNCE_CYCLES before the level is accepted,
  // so a glitch shorter than that never reaches key_level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b00;
      cnt       <= '0;
      key_level <= 1'b0;
    end else begin
      sync <= {sync[0], ~key_n};
      if (sync[1] == key_level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES)) begin
        key_level <= ~key_level;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_step_ctrl.sv
// Turns a debounced pushbutton into single-cycle core clock enables with hold-to-repeat,
// or a constant enable in free-run mode; step_en is combinational from registered state.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int REPEAT_DELAY    = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS),
  parameter int REPEAT_PERIOD   = ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS),
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  debug_step_ctrl_if.slave   bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = (REPEAT_DELAY == 0) ? '0 : RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0]       mode_sync;
  logic             run_mode;
  logic             key_level;
  step_state_t      state;
  step_state_t      state_nxt;
  logic [RW-1:0]    rcnt;
  logic [RW-1:0]    rcnt_nxt;
  logic             suppress;
  logic             suppress_nxt;
  logic             pulse;
  logic             step_en;
  logic [CNT_W-1:0] count;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk       (clk),
    .reset     (reset),
    .key_n     (bus.key_n_i),
    .key_level (key_level)
  );

  assign run_mode = mode_sync[1];

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    pulse     = 1'b0;
    case (state)
      IDLE: begin
        rcnt_nxt = '0;
        if (key_level) begin
          pulse     = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (!key_level) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rcnt == DELAY_LAST) begin
            pulse     = 1'b1;
            state_nxt = REPEAT;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!key_level) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == PERIOD_LAST) begin
          pulse    = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
    // A press that began (or was still held) in run mode stays silent until released.
    suppress_nxt = (state_nxt != IDLE) && (suppress || run_mode);
    step_en      = run_mode || (pulse && !suppress);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_sync <= 2'b00;
      state     <= IDLE;
      rcnt      <= '0;
      suppress  <= 1'b0;
      count     <= '0;
    end else begin
      mode_sync <= {mode_sync[0], bus.run_mode_i};
      state     <= state_nxt;
      rcnt      <= rcnt_nxt;
      suppress  <= suppress_nxt;
      if (step_en && !run_mode) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.step_en_o    = step_en;
  assign bus.key_level_o  = key_level;
  assign bus.run_mode_o   = run_mode;
  assign bus.step_count_o = count;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Scoreboard bench for debug_step_ctrl: expected pulse cycles are queued at stimulus time.
module tb_debug_step_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_count = 0;
  int   q[$];
  bit   mon_on = 1'b0;

  debug_step_ctrl_if #(.CNT_W(4)) dbg_if ();

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dbg_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change just after a rising edge; the next edge samples them.
  task automatic drive_at(input int t);
    while (cyc < t || clk == 1'b0) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic goto_neg(input int t);
    while (cyc < t || clk == 1'b1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (dbg_if.run_mode_o) begin
        check("run_step_en", int'(dbg_if.step_en_o), 1);
      end else if (dbg_if.step_en_o) begin
        if (q.size() == 0) check("pulse_unexpected", cyc, -1);
        else               check("pulse_cyc", cyc, q.pop_front());
      end
    end
  end

  task automatic release_key(input int e, input int hold);
    drive_at(e + hold - 1);
    dbg_if.key_n_i = 1'b1;
    goto_neg(e + hold + 5);
    check("lvl_before_fall", int'(dbg_if.key_level_o), 1);
    goto_neg(e + hold + 6);
    check("lvl_after_fall", int'(dbg_if.key_level_o), 0);
    goto_neg(e + hold + 9);
  endtask

  task automatic do_press(input int hold, input bit exp_pulse);
    int e;
    e = cyc + 3;
    drive_at(e - 1);
    dbg_if.key_n_i = 1'b0;
    if (exp_pulse) begin
      q.push_back(e + 6);
      exp_count++;
    end
    goto_neg(e + 5);
    check("lvl_before_rise", int'(dbg_if.key_level_o), 0);
    goto_neg(e + 6);
    check("lvl_after_rise", int'(dbg_if.key_level_o), 1);
    release_key(e, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int t;
    reset             = 1'b1;
    dbg_if.key_n_i    = 1'b1;
    dbg_if.run_mode_i = 1'b1;

    goto_neg(3);
    check("rst_step_en", int'(dbg_if.step_en_o), 0);
    check("rst_key_level", int'(dbg_if.key_level_o), 0);
    check("rst_run_mode", int'(dbg_if.run_mode_o), 0);
    check("rst_count", int'(dbg_if.step_count_o), 0);
    drive_at(4);
    reset             = 1'b0;
    dbg_if.run_mode_i = 1'b0;
    mon_on            = 1'b1;

    // Clean press held 30 cycles: press pulse then auto-repeat.
    drive_at(8);
    dbg_if.key_n_i = 1'b0;
    e = 9;
    q.push_back(e + 6);
    for (int k = 0; k < 7; k++) q.push_back(e + 16 + 3 * k);
    exp_count += 8;
    goto_neg(e + 5);
    check("clean_lvl_pre", int'(dbg_if.key_level_o), 0);
    goto_neg(e + 6);
    check("clean_lvl", int'(dbg_if.key_level_o), 1);
    check("clean_step_en", int'(dbg_if.step_en_o), 1);
    release_key(e, 30);
    goto_neg(e + 42);
    check("clean_count", int'(dbg_if.step_count_o), exp_count % 16);
    check("clean_q_empty", q.size(), 0);

    // Bounce: 3 low, 2 high, then steady low.
    t = cyc;
    drive_at(t + 2);
    dbg_if.key_n_i = 1'b0;
    drive_at(t + 5);
    dbg_if.key_n_i = 1'b1;
    drive_at(t + 7);
    dbg_if.key_n_i = 1'b0;
    e = t + 8;
    q.push_back(e + 6);
    exp_count++;
    goto_neg(t + 10);
    check("bounce_lvl_early", int'(dbg_if.key_level_o), 0);
    goto_neg(e + 5);
    check("bounce_lvl_pre", int'(dbg_if.key_level_o), 0);
    goto_neg(e + 6);
    check("bounce_lvl", int'(dbg_if.key_level_o), 1);
    release_key(e, 8);
    check("bounce_count", int'(dbg_if.step_count_o), exp_count % 16);

    // Short press and release; a second press proves the FSM went back to IDLE.
    do_press(8, 1'b1);
    do_press(9, 1'b1);
    check("release_count", int'(dbg_if.step_count_o), exp_count % 16);

    // Free-run mode.
    t = cyc;
    drive_at(t + 1);
    dbg_if.run_mode_i = 1'b1;
    goto_neg(t + 3);
    check("run_mode_o_hi", int'(dbg_if.run_mode_o), 1);
    for (int k = 0; k < 3; k++) do_press(8, 1'b0);
    check("run_count", int'(dbg_if.step_count_o), exp_count % 16);

    // Press in run mode, drop to step mode while held: no pulses until a re-press.
    t = cyc;
    drive_at(t + 1);
    dbg_if.key_n_i = 1'b0;
    e = t + 2;
    goto_neg(e + 8);
    check("held_lvl", int'(dbg_if.key_level_o), 1);
    drive_at(e + 9);
    dbg_if.run_mode_i = 1'b0;
    goto_neg(e + 11);
    check("switch_run_mode_o", int'(dbg_if.run_mode_o), 0);
    check("switch_step_en", int'(dbg_if.step_en_o), 0);
    goto_neg(e + 40);
    check("switch_held_step_en", int'(dbg_if.step_en_o), 0);
    drive_at(e + 41);
    dbg_if.key_n_i = 1'b1;
    goto_neg(e + 52);
    check("switch_count", int'(dbg_if.step_count_o), exp_count % 16);
    do_press(8, 1'b1);
    check("repress_count", int'(dbg_if.step_count_o), exp_count % 16);

    // Reset in mid-debounce, key held through reset release.
    t = cyc;
    drive_at(t + 1);
    dbg_if.key_n_i = 1'b0;
    e = t + 2;
    drive_at(e + 3);
    reset = 1'b1;
    goto_neg(e + 4);
    check("midrst_key_level", int'(dbg_if.key_level_o), 0);
    check("midrst_step_en", int'(dbg_if.step_en_o), 0);
    check("midrst_count", int'(dbg_if.step_count_o), 0);
    check("midrst_run_mode", int'(dbg_if.run_mode_o), 0);
    exp_count = 1;
    q.push_back(e + 13);
    drive_at(e + 6);
    reset = 1'b0;
    goto_neg(e + 12);
    check("rstrel_lvl_pre", int'(dbg_if.key_level_o), 0);
    goto_neg(e + 13);
    check("rstrel_lvl", int'(dbg_if.key_level_o), 1);
    drive_at(e + 15);
    dbg_if.key_n_i = 1'b1;
    goto_neg(e + 26);
    check("rstrel_count", int'(dbg_if.step_count_o), exp_count);

    // 17 short presses from a fresh reset wrap the 4-bit counter to 1.
    t = cyc;
    drive_at(t + 1);
    reset = 1'b1;
    drive_at(t + 3);
    reset = 1'b0;
    exp_count = 0;
    goto_neg(t + 4);
    check("wrap_start", int'(dbg_if.step_count_o), 0);
    for (int k = 0; k < 17; k++) do_press(8, 1'b1);
    check("wrap_count", int'(dbg_if.step_count_o), 1);
    check("wrap_count_model", int'(dbg_if.step_count_o), exp_count % 16);

    check("final_q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
